// File: rtl/snn_frame_loader_if.sv
// Handshake/bus bundle between the JTAG word bank, the frame loader and run_network.
// The slave side is the loader; the master side is whoever drives chunks and network results.
interface snn_frame_loader_if #(
  parameter int WORDS    = 14,
  parameter int IMG_BITS = 800
);
  logic [WORDS*32-1:0]  iWORDS;
  logic                 iNEXT;
  logic                 iFINISH;
  logic                 iCLR_ERR;
  logic                 iSNN_DONE;
  logic [1:0]           iSNN_OUT;
  logic [IMG_BITS-1:0]  oIMAGE;
  logic                 oIMAGE_VALID;
  logic                 oSNN_START;
  logic [1:0]           oRESULT;
  logic                 oRESULT_VALID;
  logic                 oBUSY;
  logic                 oPROTO_ERR;
  logic                 oTIMEOUT;

  modport master (
    output iWORDS, iNEXT, iFINISH, iCLR_ERR, iSNN_DONE, iSNN_OUT,
    input  oIMAGE, oIMAGE_VALID, oSNN_START, oRESULT, oRESULT_VALID,
           oBUSY, oPROTO_ERR, oTIMEOUT
  );

  modport slave (
    input  iWORDS, iNEXT, iFINISH, iCLR_ERR, iSNN_DONE, iSNN_OUT,
    output oIMAGE, oIMAGE_VALID, oSNN_START, oRESULT, oRESULT_VALID,
           oBUSY, oPROTO_ERR, oTIMEOUT
  );
endinterface

// File: rtl/snn_frame_loader.sv
// Copies JTAG chunks word-by-word into the SNN pixel buffer, starts the network,
// and latches its classification; flags protocol errors and run timeouts.
//
// state   | meaning
// S_IDLE  | waiting for a synchronised iNEXT rising edge
// S_COPY  | writing one held word per cycle into the image buffer
// S_START | issuing the one-cycle network start pulse
// S_RUN   | waiting for iSNN_DONE or the timeout count
module snn_frame_loader #(
  parameter int WORDS    = 14,
  parameter int IMG_BITS = 800,
  parameter int TIMEOUT  = 4095
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  snn_frame_loader_if.slave bus
);

  localparam int          CHUNK_BITS = WORDS * 32;
  localparam int          IMG_WORDS  = IMG_BITS / 32;
  localparam logic [11:0] TO_LAST    = 12'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_START, S_RUN} state_t;

  state_t               r_state;
  logic [2:0]           r_next_sync;
  logic [1:0]           r_fin_sync;
  logic [WORDS*32-1:0]  r_hold;
  logic                 r_last;
  logic [7:0]           r_idx;
  logic [7:0]           r_w;
  logic [11:0]          r_cnt;
  logic [IMG_BITS-1:0]  r_image;
  logic                 r_img_valid;
  logic                 r_start;
  logic [1:0]           r_result;
  logic                 r_res_valid;
  logic                 r_proto_err;
  logic                 r_timeout;

  logic                 w_next_edge;
  logic [15:0]          w_img_word;
  logic                 w_img_ok;
  logic [31:0]          w_word;
  logic                 w_last_word;
  logic                 w_no_room;

  assign w_next_edge = r_next_sync[1] & ~r_next_sync[2];
  assign w_img_word  = 16'(r_idx) * 16'(WORDS) + 16'(r_w);
  assign w_img_ok    = w_img_word < 16'(IMG_WORDS);
  assign w_word      = r_hold[{r_w, 5'b0} +: 32];
  assign w_last_word = r_w == 8'(WORDS - 1);
  // Room check for the chunk that would follow this one
  assign w_no_room   = (32'(r_idx) + 32'd1) * 32'(CHUNK_BITS) >= 32'(IMG_BITS);

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_state     <= S_IDLE;
      r_next_sync <= '0;
      r_fin_sync  <= '0;
      r_hold      <= '0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_w         <= '0;
      r_cnt       <= '0;
      r_image     <= '0;
      r_img_valid <= 1'b0;
      r_start     <= 1'b0;
      r_result    <= '0;
      r_res_valid <= 1'b0;
      r_proto_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_next_sync <= {r_next_sync[1:0], bus.iNEXT};
      r_fin_sync  <= {r_fin_sync[0], bus.iFINISH};
      r_start     <= 1'b0;

      // Error sets below are later assignments, so they override this clear
      if (bus.iCLR_ERR) begin
        r_proto_err <= 1'b0;
        r_timeout   <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_next_edge) begin
            r_hold  <= bus.iWORDS;
            r_last  <= r_fin_sync[1];
            r_w     <= '0;
            r_state <= S_COPY;
            if (r_idx == '0) begin
              r_img_valid <= 1'b0;
              r_res_valid <= 1'b0;
            end
          end
        end

        S_COPY: begin
          if (w_next_edge) r_proto_err <= 1'b1;
          if (w_img_ok) r_image[{w_img_word, 5'b0} +: 32] <= w_word;
          if (w_last_word) begin
            if (r_last) begin
              r_idx       <= '0;
              r_img_valid <= 1'b1;
              r_state     <= S_START;
            end else if (w_no_room) begin
              r_proto_err <= 1'b1;
              r_idx       <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_state <= S_IDLE;
            end
          end else begin
            r_w <= r_w + 8'd1;
          end
        end

        S_START: begin
          if (w_next_edge) r_proto_err <= 1'b1;
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (w_next_edge) r_proto_err <= 1'b1;
          if (bus.iSNN_DONE) begin
            r_result    <= bus.iSNN_OUT;
            r_res_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else if (r_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.oIMAGE        = r_image;
  assign bus.oIMAGE_VALID  = r_img_valid;
  assign bus.oSNN_START    = r_start;
  assign bus.oRESULT       = r_result;
  assign bus.oRESULT_VALID = r_res_valid;
  assign bus.oBUSY         = r_state != S_IDLE;
  assign bus.oPROTO_ERR    = r_proto_err;
  assign bus.oTIMEOUT      = r_timeout;

endmodule

// File: tb/tb_snn_frame_loader.sv
// Directed bench for snn_frame_loader: frame assembly, start/result handshake,
// overflow and mid-copy protocol errors, run timeout, and async reset.
module tb_snn_frame_loader;
  localparam int WORDS    = 14;
  localparam int IMG_BITS = 800;
  localparam int TIMEOUT  = 20;

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } img_vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  snn_frame_loader_if #(.WORDS(WORDS), .IMG_BITS(IMG_BITS)) bus ();

  snn_frame_loader #(.WORDS(WORDS), .IMG_BITS(IMG_BITS), .TIMEOUT(TIMEOUT)) dut (
    .iCLK    (clk),
    .iRESETn (rst_n),
    .bus     (bus)
  );

  always @(negedge clk) if (bus.oSNN_START === 1'b1) start_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] img_word(input int i);
    return bus.oIMAGE[i*32 +: 32];
  endfunction

  task automatic set_words(input logic [31:0] base);
    for (int w = 0; w < WORDS; w++) bus.iWORDS[w*32 +: 32] = base + 32'(w);
  endtask

  task automatic wait_busy(input logic level, input int bound, input string name);
    int n = 0;
    while (bus.oBUSY !== level && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(bus.oBUSY), 64'(level));
  endtask

  task automatic wait_start(input int bound, input string name);
    int n = 0;
    while (bus.oSNN_START !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(bus.oSNN_START), 64'd1);
  endtask

  task automatic raise(input logic [31:0] base, input logic fin);
    set_words(base);
    bus.iFINISH = fin;
    bus.iNEXT   = 1'b1;
    wait_busy(1'b1, 10, "busy_on_edge");
  endtask

  task automatic drop();
    bus.iNEXT   = 1'b0;
    bus.iFINISH = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.iCLR_ERR = 1'b1;
    @(negedge clk);
    bus.iCLR_ERR = 1'b0;
  endtask

  img_vec_t frame_tab[6];

  initial begin
    int n;
    logic [31:0] exp_w;

    frame_tab[0] = '{0,  32'hA5A5_0000};
    frame_tab[1] = '{7,  32'hA5A5_0007};
    frame_tab[2] = '{13, 32'hA5A5_000D};
    frame_tab[3] = '{14, 32'h5A5A_0000};
    frame_tab[4] = '{20, 32'h5A5A_0006};
    frame_tab[5] = '{24, 32'h5A5A_000A};

    bus.iWORDS    = '0;
    bus.iNEXT     = 1'b0;
    bus.iFINISH   = 1'b0;
    bus.iCLR_ERR  = 1'b0;
    bus.iSNN_DONE = 1'b0;
    bus.iSNN_OUT  = 2'b00;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_image",  64'(|bus.oIMAGE), 64'd0);
    chk("rst_flags",  64'({bus.oIMAGE_VALID, bus.oSNN_START, bus.oRESULT, bus.oRESULT_VALID,
                           bus.oPROTO_ERR, bus.oTIMEOUT}), 64'd0);
    chk("rst_busy",   64'(bus.oBUSY), 64'd0);

    // Two-chunk frame; chunk 1 words 11..13 fall past the 800-bit buffer
    raise(32'hA5A5_0000, 1'b0);
    wait_busy(1'b0, 40, "chunk0_done");
    chk("chunk0_no_valid", 64'(bus.oIMAGE_VALID), 64'd0);
    drop();
    raise(32'h5A5A_0000, 1'b1);
    n = 0;
    while (bus.oIMAGE_VALID !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("img_valid_set",   64'(bus.oIMAGE_VALID), 64'd1);
    chk("start_not_early", 64'(bus.oSNN_START), 64'd0);
    @(negedge clk);
    chk("start_pulse",     64'(bus.oSNN_START), 64'd1);
    @(negedge clk);
    chk("start_one_cycle", 64'(bus.oSNN_START), 64'd0);
    chk("busy_in_run",     64'(bus.oBUSY), 64'd1);

    for (int i = 0; i < 6; i++)
      chk($sformatf("tab_word%0d", frame_tab[i].idx), 64'(img_word(frame_tab[i].idx)),
          64'(frame_tab[i].exp));
    for (int i = 0; i < IMG_BITS/32; i++) begin
      exp_w = (i < WORDS) ? 32'hA5A5_0000 + 32'(i) : 32'h5A5A_0000 + 32'(i - WORDS);
      chk($sformatf("img_word%0d", i), 64'(img_word(i)), 64'(exp_w));
    end
    drop();

    bus.iSNN_DONE = 1'b1;
    bus.iSNN_OUT  = 2'b10;
    @(negedge clk);
    bus.iSNN_DONE = 1'b0;
    bus.iSNN_OUT  = 2'b00;
    chk("result",       64'(bus.oRESULT), 64'h2);
    chk("result_valid", 64'(bus.oRESULT_VALID), 64'd1);
    chk("busy_after",   64'(bus.oBUSY), 64'd0);
    chk("start_count",  64'(start_cnt), 64'd1);

    // New chunk 0 clears both valid flags
    raise(32'h1111_0000, 1'b0);
    chk("clr_img_valid", 64'(bus.oIMAGE_VALID), 64'd0);
    chk("clr_res_valid", 64'(bus.oRESULT_VALID), 64'd0);
    wait_busy(1'b0, 40, "c0b_done");
    chk("c0b_word0", 64'(img_word(0)), 64'h1111_0000);
    drop();

    // Second chunk without FINISH leaves no room for a third
    raise(32'h2222_0000, 1'b0);
    wait_busy(1'b0, 40, "c1b_done");
    chk("overflow_err", 64'(bus.oPROTO_ERR), 64'd1);
    chk("c1b_word14",   64'(img_word(14)), 64'h2222_0000);
    drop();
    raise(32'h3333_0000, 1'b0);
    wait_busy(1'b0, 40, "c2b_done");
    chk("idx_wrapped",  64'(img_word(0)), 64'h3333_0000);
    chk("err_sticky",   64'(bus.oPROTO_ERR), 64'd1);
    drop();
    pulse_clr();
    chk("err_cleared",  64'(bus.oPROTO_ERR), 64'd0);

    // Timeout: network never answers
    raise(32'h4444_0000, 1'b1);
    wait_start(40, "to_start");
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("to_not_yet",   64'(bus.oTIMEOUT), 64'd0);
    chk("to_busy",      64'(bus.oBUSY), 64'd1);
    @(negedge clk);
    chk("to_set",       64'(bus.oTIMEOUT), 64'd1);
    chk("to_idle",      64'(bus.oBUSY), 64'd0);
    chk("to_no_result", 64'(bus.oRESULT_VALID), 64'd0);
    chk("to_img_valid", 64'(bus.oIMAGE_VALID), 64'd1);
    drop();

    bus.iSNN_DONE = 1'b1;
    bus.iSNN_OUT  = 2'b11;
    @(negedge clk);
    bus.iSNN_DONE = 1'b0;
    chk("done_idle_result", 64'(bus.oRESULT), 64'h2);
    chk("done_idle_valid",  64'(bus.oRESULT_VALID), 64'd0);
    chk("done_idle_noerr",  64'(bus.oPROTO_ERR), 64'd0);
    pulse_clr();
    chk("to_cleared",       64'(bus.oTIMEOUT), 64'd0);

    // Done on the terminal cycle wins over the timeout
    raise(32'h5555_0000, 1'b1);
    wait_start(40, "tie_start");
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("tie_not_yet", 64'(bus.oTIMEOUT), 64'd0);
    bus.iSNN_DONE = 1'b1;
    bus.iSNN_OUT  = 2'b01;
    @(negedge clk);
    bus.iSNN_DONE = 1'b0;
    chk("tie_result",  64'(bus.oRESULT), 64'h1);
    chk("tie_valid",   64'(bus.oRESULT_VALID), 64'd1);
    chk("tie_no_to",   64'(bus.oTIMEOUT), 64'd0);
    chk("tie_idle",    64'(bus.oBUSY), 64'd0);
    drop();

    // Second iNEXT edge while copying is rejected
    raise(32'h6666_0000, 1'b0);
    bus.iNEXT = 1'b0;
    set_words(32'h7777_0000);
    repeat (2) @(negedge clk);
    bus.iNEXT = 1'b1;
    wait_busy(1'b0, 40, "glitch_done");
    chk("glitch_err",    64'(bus.oPROTO_ERR), 64'd1);
    chk("glitch_word0",  64'(img_word(0)), 64'h6666_0000);
    chk("glitch_word13", 64'(img_word(13)), 64'h6666_000D);
    drop();

    // Async reset in the middle of a copy
    raise(32'h8888_0000, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_image", 64'(|bus.oIMAGE), 64'd0);
    chk("arst_flags", 64'({bus.oIMAGE_VALID, bus.oSNN_START, bus.oRESULT, bus.oRESULT_VALID,
                           bus.oPROTO_ERR, bus.oTIMEOUT}), 64'd0);
    chk("arst_busy",  64'(bus.oBUSY), 64'd0);
    bus.iNEXT   = 1'b0;
    bus.iFINISH = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // After reset the next chunk lands at chunk 0
    raise(32'h9999_0000, 1'b1);
    wait_start(40, "post_rst_start");
    chk("post_rst_word0",  64'(img_word(0)), 64'h9999_0000);
    chk("post_rst_word14", 64'(img_word(14)), 64'd0);
    chk("post_rst_valid",  64'(bus.oIMAGE_VALID), 64'd1);
    drop();
    bus.iSNN_DONE = 1'b1;
    bus.iSNN_OUT  = 2'b11;
    @(negedge clk);
    bus.iSNN_DONE = 1'b0;
    chk("post_rst_result", 64'(bus.oRESULT), 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
